// File: rtl/ab_pattern_sequencer.sv
// Clocked, restartable a/b stimulus source for the downstream `hierarchy` block.
// Steps through PATTERN, holds each vector HOLD_CYCLES clocks and logs c_in at the end of each hold.
module ab_pattern_sequencer #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned NUM_STEPS   = 6,
  parameter logic [2*NUM_STEPS-1:0] PATTERN = 12'h6E4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 c_in,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
  output logic [((NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1)-1:0] step_idx,
  output logic [NUM_STEPS-1:0] c_log
);

  localparam int unsigned SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          hold_end;
  logic          last_step;

  function automatic logic [1:0] vec_at(input int unsigned i);
    return PATTERN[2*i +: 2];
  endfunction

  assign hold_end  = (cnt == CW'(HOLD_CYCLES - 1));
  assign last_step = (step_idx == SW'(NUM_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      a            <= 1'b0;
      b            <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      step_idx     <= '0;
      c_log        <= '0;
    end else begin
      done         <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          a        <= 1'b0;
          b        <= 1'b0;
          step_idx <= '0;
          cnt      <= '0;
          // abort has priority over a simultaneous start
          if (start && !abort) begin
            state    <= S_DRIVE;
            busy     <= 1'b1;
            c_log    <= '0;
            {a, b}   <= vec_at(0);
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            a        <= 1'b0;
            b        <= 1'b0;
            step_idx <= '0;
            cnt      <= '0;
          end else if (hold_end) begin
            cnt          <= '0;
            sample_valid <= 1'b1;
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
              if (SW'(i) == step_idx) c_log[i] <= c_in;
            end
            if (last_step) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              a     <= 1'b0;
              b     <= 1'b0;
            end else begin
              step_idx <= step_idx + 1'b1;
              {a, b}   <= vec_at(32'(step_idx) + 1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          step_idx <= '0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          a     <= 1'b0;
          b     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ab_pattern_sequencer.sv
// Bench for ab_pattern_sequencer: default build plus a HOLD_CYCLES=1/NUM_STEPS=1 build.
// The downstream block is modelled as a 4-entry truth table indexed by {a,b}.
module tb_ab_pattern_sequencer;

  localparam int          N0 = 6;
  localparam int          H0 = 8;
  localparam logic [11:0] P0 = 12'h6E4;
  localparam int          N1 = 1;
  localparam int          H1 = 1;
  localparam logic [1:0]  P1 = 2'b11;
  localparam int          NEVER = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, sel;
  logic [3:0] tt;

  logic a0, b0, busy0, done0, sv0, c0;
  logic [2:0] si0;
  logic [5:0] cl0;
  logic a1, b1, busy1, done1, sv1, c1;
  logic [0:0] si1;
  logic [0:0] cl1;

  assign c0 = tt[{a0, b0}];
  assign c1 = tt[{a1, b1}];

  ab_pattern_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel), .c_in(c0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .sample_valid(sv0),
    .step_idx(si0), .c_log(cl0)
  );

  ab_pattern_sequencer #(.HOLD_CYCLES(H1), .NUM_STEPS(N1), .PATTERN(P1)) dut1 (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel), .c_in(c1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sample_valid(sv1),
    .step_idx(si1), .c_log(cl1)
  );

  logic        o_a, o_b, o_busy, o_done, o_sv;
  logic [31:0] o_si, o_log;
  always_comb begin
    o_a    = sel ? a1 : a0;
    o_b    = sel ? b1 : b0;
    o_busy = sel ? busy1 : busy0;
    o_done = sel ? done1 : done0;
    o_sv   = sel ? sv1 : sv0;
    o_si   = sel ? 32'(si1) : 32'(si0);
    o_log  = sel ? 32'(cl1) : 32'(cl0);
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] mvec(input int s);
    logic [63:0] pat;
    pat = sel ? 64'(P1) : 64'(P0);
    return pat[2*s +: 2];
  endfunction

  // k = number of edges since the start edge; stop_at = edge on which abort/rst is seen
  task automatic check_cycle(input int k, input int stop_at, input bit stop_rst);
    int n, h, total;
    bit alive, run;
    logic [1:0]  e_ab;
    logic [31:0] e_si, e_log;
    n = sel ? N1 : N0;
    h = sel ? H1 : H0;
    total = n * h;
    alive = (k < stop_at);
    run   = alive && (k < total);
    e_ab  = run ? mvec(k / h) : 2'b00;
    if (!alive)          e_si = 0;
    else if (k < total)  e_si = 32'(k / h);
    else if (k == total) e_si = 32'(n - 1);
    else                 e_si = 0;
    e_log = '0;
    for (int s = 0; s < n; s++)
      if ((s + 1) * h <= k && (s + 1) * h < stop_at) e_log[s] = tt[mvec(s)];
    if (!alive && stop_rst) e_log = '0;
    chk("a", 32'(o_a), 32'(e_ab[1]));
    chk("b", 32'(o_b), 32'(e_ab[0]));
    chk("busy", 32'(o_busy), 32'(run));
    chk("done", 32'(o_done), 32'(alive && k == total));
    chk("sample_valid", 32'(o_sv), 32'(alive && k > 0 && k % h == 0 && k <= total));
    chk("step_idx", o_si, e_si);
    chk("c_log", o_log, e_log);
  endtask

  task automatic run_seq(input logic [3:0] t, input int stop_at, input bit stop_rst,
                         input int s1, input int s2);
    int total;
    total = sel ? N1 * H1 : N0 * H0;
    tt = t;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= total + 1; k++) begin
      check_cycle(k, stop_at, stop_rst);
      start = (k == s1) || (k == s2);
      abort = !stop_rst && (k + 1 == stop_at);
      rst   = stop_rst && (k + 1 == stop_at);
      if (k < total + 1) tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; sel = 1'b0; tt = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_ab", 32'({a0, b0, done0, sv0}), 0);
      chk("rst_idx_log", 32'({si0, cl0}), 0);
    end
    rst = 1'b0; start = 1'b0;
    tick();

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy0), 0);
    chk("start_abort_ab", 32'({a0, b0}), 0);
    tick();
    chk("start_abort_idle", 32'(busy0), 0);

    run_seq(4'b0110, NEVER, 1'b0, -1, -1);   // c = a^b
    run_seq(4'b1000, NEVER, 1'b0, -1, 48);   // c = a&b, start during DONE ignored
    run_seq(4'b1000, NEVER, 1'b0, -1, -1);   // back-to-back rerun
    run_seq(4'b0110, 20, 1'b0, -1, -1);      // abort in step 2
    run_seq(4'b0110, NEVER, 1'b0, 5, 30);    // start while busy ignored
    run_seq(4'b0110, 48, 1'b0, -1, -1);      // abort on final sample edge
    run_seq(4'b0110, 25, 1'b1, -1, -1);      // rst mid-sequence
    tick();
    for (int r = 0; r < 4; r++) begin
      int sa;
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 48)) : NEVER;
      run_seq(4'($urandom_range(0, 15)), sa, 1'b0, -1, -1);
    end

    sel = 1'b1;
    tick();
    run_seq(4'b1000, NEVER, 1'b0, -1, -1);
    run_seq(4'($urandom_range(0, 15)), NEVER, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
